remote_key_dispatcher: RTL
==========================

Name: remote_key_dispatcher

Overview:
- Sits downstream of the IR remote decoder and consumes its Tecla/Ready output.
- Turns each decoded frame into one key event and suppresses auto-repeat of a held key.
- Buffers events in a small FIFO and hands them one at a time to a consumer over a valid/ack handshake with an ack timeout.
- It is the scheduler between the decoder's bursty 3-cycle Ready strobe and slower command logic.

Parameters:
- FIFO_DEPTH, 4, number of queued key events; power of 2, 2..16.
- HOLDOFF_CYCLES, 1000, repeat-suppression window in clocks; 1..65535.
- ACK_TIMEOUT, 255, clocks CmdValid may stay unacknowledged before the event is discarded; 1..65535.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset. Asserts asynchronously; all state is cleared while low.
- Tecla  in  8  key code from the decoder; meaningful only while Ready=1.
- Ready  in  1  decoder strobe; high for 3 consecutive cycles per valid frame.
- Clear  in  1  synchronous clear of FIFO, holdoff, Overflow and dispatcher.
- Cmd  out  8  key code being presented.
- CmdValid  out  1  Cmd is valid; held until accepted or timed out.
- CmdAck  in  1  consumer accepts Cmd in the cycle CmdAck=1 and CmdValid=1.
- Dropped  out  1  one-cycle pulse when a presented event times out.
- Overflow  out  1  sticky; an event was lost because the FIFO was full.
- Count  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values: Cmd=0, CmdValid=0, Dropped=0, Overflow=0, Count=0, FSM=IDLE, ready_d=0, last_key=0, holdoff=0.
- Capture:
  - capture = Ready & ~ready_d, where ready_d is Ready registered.
  - Exactly one capture per strobe, on its first high cycle. Tecla is sampled in that cycle.
- Repeat filter:
  - On capture, if holdoff!=0 and Tecla==last_key, the event is suppressed.
  - Otherwise it is pushed.
  - Every capture, suppressed or pushed, reloads holdoff=HOLDOFF_CYCLES and sets last_key=Tecla. A held key therefore stays suppressed for as long as repeats arrive closer than the window.
  - holdoff decrements by 1 per cycle and saturates at 0.
- FIFO:
  - Circular buffer with wrapping read/write pointers.
  - Push when full and no pop in the same cycle: event discarded, Overflow<=1 (sticky until Clear or Reset), Count unchanged.
  - Push and pop in the same cycle: both happen, Count unchanged. This is legal when full.
  - Pop when empty never occurs.
- Dispatcher FSM:
  - IDLE:
    - If Count!=0: pop head into Cmd, CmdValid<=1, timer<=0, go PRESENT.
    - Else stay.
  - PRESENT:
    - Cmd is stable. CmdValid=1.
    - If CmdAck: CmdValid<=0, go IDLE.
    - Else if timer==ACK_TIMEOUT-1: CmdValid<=0, Dropped<=1 for one cycle, go IDLE.
    - Else timer++.
    - CmdAck takes priority over timeout in the same cycle.
  - There is one idle cycle between consecutive events. Maximum throughput is 1 event per 2 clocks plus consumer latency.
- Latency: Ready first high in cycle k pushes at edge k. The FIFO is non-empty in cycle k+1, so CmdValid=1 and Cmd is valid from cycle k+2.
- Clear:
  - Takes priority over capture, push, pop and ack.
  - Next cycle: FIFO empty, Count=0, Overflow=0, holdoff=0, last_key=0, CmdValid=0, Dropped=0, FSM=IDLE.
  - An in-flight Cmd is abandoned without a Dropped pulse.
- Reset mid-operation: all registers return to reset values immediately. A Ready strobe still high when Reset releases does not produce a capture unless ready_d=0 and Ready=1 in the first cycle after release. This is intended; the frame is counted as new.
- Width rules: Count is wide enough to hold FIFO_DEPTH. holdoff and timer are 16 bits.

Test Plan:
- Single key: Reset low then high; strobe Ready 3 cycles with Tecla=8'h45; CmdAck=1 on first CmdValid -> CmdValid rises 2 cycles after Ready rises, Cmd=8'h45 for one cycle; Count 0->1->0; Dropped=0.
- Repeat suppression (HOLDOFF_CYCLES=20): 8'h45 strobes at t=0, 10, 25; 8'h46 at t=30 -> only 8'h45 (t=0) and 8'h46 are dispatched. The t=10 and t=25 repeats are suppressed because each reloads the window.
- Overflow: CmdAck=0, ACK_TIMEOUT large; send 6 distinct keys 8'h01..8'h06 -> Count reaches 4 while 8'h01 is presented. 8'h01 is already popped, so the FIFO holds 8'h02..8'h05, 8'h06 is lost and Overflow=1. Ack all -> order 01,02,03,04,05; Overflow stays 1 until Clear.
- Timeout (ACK_TIMEOUT=8): key 8'h10, CmdAck held 0 -> CmdValid high exactly 8 cycles, then Dropped pulses 1 cycle, CmdValid=0, FSM returns to IDLE; the next key 8'h11 is presented normally.
- Ack/timeout tie and simultaneous push/pop: CmdAck=1 in the timeout cycle -> no Dropped. A capture in the same cycle as an IDLE pop with the FIFO full -> event accepted, Count unchanged, Overflow=0.
- Clear and Reset mid-operation: with 3 queued events and CmdValid=1, pulse Clear -> next cycle Count=0, CmdValid=0, Overflow=0, no Dropped. Repeat with Reset low asynchronously mid-cycle -> outputs go to reset values before the next clock edge.

Source files
------------

// File: rtl/remote_key_dispatcher.sv
// Turns decoder Ready strobes into single key events, filters auto-repeat, queues them and
// presents them one at a time over a valid/ack handshake with an ack timeout.
module remote_key_dispatcher #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned HOLDOFF_CYCLES = 1000,
  parameter int unsigned ACK_TIMEOUT    = 255
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic [7:0]                    Tecla,
  input  logic                          Ready,
  input  logic                          Clear,
  output logic [7:0]                    Cmd,
  output logic                          CmdValid,
  input  logic                          CmdAck,
  output logic                          Dropped,
  output logic                          Overflow,
  output logic [$clog2(FIFO_DEPTH):0]   Count
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [15:0] HoldoffLoad = 16'(HOLDOFF_CYCLES);
  localparam logic [15:0] TimeoutLast = 16'(ACK_TIMEOUT - 1);
  localparam logic [CntW-1:0] CountFull = CntW'(FIFO_DEPTH);

  typedef enum logic {StIdle, StPresent} state_e;

  state_e          state_q, state_d;
  logic            ready_d;
  logic [7:0]      last_key;
  logic [15:0]     holdoff;
  logic [15:0]     timer_q, timer_d;
  logic [7:0]      cmd_d;
  logic            valid_d, dropped_d;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr, rd_ptr;

  logic capture, suppress, push, pop, full, wr_en;

  assign capture  = Ready & ~ready_d;
  assign suppress = capture && (holdoff != 16'd0) && (Tecla == last_key);
  assign push     = capture & ~suppress;
  assign pop      = (state_q == StIdle) && (Count != '0);
  assign full     = (Count == CountFull);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign wr_en    = push && (!full || pop);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      ready_d  <= 1'b0;
      last_key <= 8'h00;
      holdoff  <= 16'd0;
    end else begin
      ready_d <= Ready;
      if (Clear) begin
        last_key <= 8'h00;
        holdoff  <= 16'd0;
      end else if (capture) begin
        last_key <= Tecla;
        holdoff  <= HoldoffLoad;
      end else if (holdoff != 16'd0) begin
        holdoff <= holdoff - 16'd1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Clear && wr_en) begin
      mem[wr_ptr] <= Tecla;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      Count    <= '0;
      Overflow <= 1'b0;
    end else if (Clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      Count    <= '0;
      Overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PtrW'(1);
      if (pop)   rd_ptr <= rd_ptr + PtrW'(1);
      if (wr_en && !pop) begin
        Count <= Count + CntW'(1);
      end else if (pop && !wr_en) begin
        Count <= Count - CntW'(1);
      end
      if (push && full && !pop) Overflow <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    cmd_d     = Cmd;
    valid_d   = CmdValid;
    dropped_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          cmd_d   = mem[rd_ptr];
          valid_d = 1'b1;
          timer_d = 16'd0;
          state_d = StPresent;
        end
      end
      StPresent: begin
        // Ack wins over a timeout landing in the same cycle.
        if (CmdAck) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end else if (timer_q == TimeoutLast) begin
          valid_d   = 1'b0;
          dropped_d = 1'b1;
          state_d   = StIdle;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q  <= StIdle;
      timer_q  <= 16'd0;
      Cmd      <= 8'h00;
      CmdValid <= 1'b0;
      Dropped  <= 1'b0;
    end else if (Clear) begin
      state_q  <= StIdle;
      timer_q  <= 16'd0;
      CmdValid <= 1'b0;
      Dropped  <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      Cmd      <= cmd_d;
      CmdValid <= valid_d;
      Dropped  <= dropped_d;
    end
  end

endmodule
